mac_operand_seq: RTL and testbench
==================================

Name: mac_operand_seq

Overview:
Sequencer that drives one MAC accumulator unit from the operand side. It accepts a dot-product job of `len` operand pairs over a valid/ready stream and issues the MAC's clear and enable strobes with the operands. It then waits for the final accumulation, captures the MAC's `Cout`, and returns the result over a valid/ready result port. It sits between the operand buffers and the MAC array in the minilab datapath.

Parameters:
- DATA_WIDTH, 8: operand width; result width is 3*DATA_WIDTH, matching the MAC.
- LEN_WIDTH, 4: width of the job length; max job is 2^LEN_WIDTH-1 pairs.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_WIDTH  pair count; latched with `start`.
- abort  in  1  cancels the current job; no result is produced.
- busy  out  1  high in every state except IDLE.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  high only in FEED.
- op_a  in  DATA_WIDTH  operand A.
- op_b  in  DATA_WIDTH  operand B.
- mac_clr  out  1  MAC clear strobe.
- mac_en  out  1  MAC accumulate enable.
- mac_a  out  DATA_WIDTH  registered copy of op_a.
- mac_b  out  DATA_WIDTH  registered copy of op_b.
- mac_cout  in  3*DATA_WIDTH  MAC accumulator value.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  3*DATA_WIDTH  captured result.
- res_count  out  LEN_WIDTH  pair count of the result's job.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; the remaining-pair counter goes to 0.
  - busy, op_ready, mac_clr, mac_en, res_valid = 0.
  - mac_a, mac_b, res_data, res_count = 0.
  - Reset during any state discards the job; the MAC is not cleared by reset, because the next job clears it.
- MAC contract: `Clr` and `En` act at the clock edge. `Cout` reflects an accumulate on the cycle after `En` was high.
- States: IDLE, CLR, FEED, WAIT, DONE.
- IDLE:
  - start=1 latches len into rem and job_len; next state is CLR.
- CLR:
  - mac_clr=1 for exactly this one cycle.
  - Next state is FEED if rem!=0, otherwise WAIT.
- FEED:
  - op_ready=1. On op_valid & op_ready, the next cycle has mac_en=1, mac_a=op_a, mac_b=op_b, and rem is decremented.
  - Any cycle without a handshake produces mac_en=0 in the next cycle; mac_a and mac_b hold their values.
  - The handshake that brings rem to 0 moves the block to WAIT.
- WAIT:
  - Exactly 2 cycles, counted internally.
  - Cycle 1 carries mac_en for the last pair (or nothing when len=0).
  - In cycle 2, mac_cout is final; at the end of cycle 2, res_data<=mac_cout, res_count<=job_len, and the state goes to DONE.
- DONE:
  - res_valid=1; res_data and res_count are held stable until res_valid & res_ready.
  - On that handshake, the block returns to IDLE and res_valid=0 in the next cycle.
  - start is ignored while in DONE.
- Latency with op_valid held high and start accepted at cycle 0:
  - CLR in cycle 1.
  - FEED in cycles 2..N+1.
  - WAIT in cycles N+2..N+3.
  - res_valid first high in cycle N+4.
- len=0: res_valid in cycle 4 with res_data=0.
- abort:
  - In any state except IDLE, the next state is IDLE; op_ready, mac_en, mac_clr and res_valid drop the next cycle; no result is produced.
  - A result not yet accepted in DONE is dropped.
  - abort in IDLE is ignored.
  - rst takes priority over abort, and abort takes priority over start.
- Arithmetic: the result wraps modulo 2^(3*DATA_WIDTH), exactly as the MAC does; there is no overflow flag.
- mac_en and mac_clr are never high in the same cycle.

Test Plan:
- len=3, pairs (2,3),(4,5),(255,255), op_valid always high, start at cycle 0 -> mac_clr high in cycle 1 only; mac_en high in cycles 3-5; res_valid in cycle 7; res_data=65051; res_count=3.
- Same job with op_valid low on alternate cycles -> mac_en pulses only after handshakes; res_data=65051; res_valid 3 cycles after the last handshake.
- len=0 -> no op_ready; res_valid in cycle 4; res_data=0; res_count=0.
- res_ready held low for 10 cycles in DONE, with start pulsed during it -> res_data stable and busy=1 throughout; start ignored; single accept, then IDLE.
- abort in FEED after 1 of 4 pairs; separately, rst in WAIT -> IDLE the next cycle; no res_valid. A following job len=1 with (1,1) -> res_data=1, showing the MAC was cleared.
- Back-to-back jobs: len=2 (10,10),(10,10) -> 200; then start with len=1 (7,3) on the cycle after acceptance -> 21.

Source files
------------

// File: rtl/mac_operand_seq.sv
//-----------------------------------------------------------------------------
// mac_operand_seq
//
// Operand-side sequencer for one MAC accumulator. It accepts a dot-product
// job of `len` operand pairs, clears the MAC, streams the pairs into it with
// mac_en, waits for the final accumulation to appear on mac_cout, and returns
// the captured sum over a valid/ready result port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, len          job request and pair count (sampled in IDLE only)
//   abort               drop the current job (ignored in IDLE)
//   busy                high whenever a job is in progress
//   op_valid/op_ready   operand pair handshake, op_a/op_b the pair
//   mac_clr, mac_en     MAC clear / accumulate strobes
//   mac_a, mac_b        registered operands presented with mac_en
//   mac_cout            MAC accumulator value
//   res_valid/res_ready result handshake
//   res_data, res_count captured sum and the job's pair count
//
// Every output is a flop; the next value of each output strobe is decoded
// from the next state so the strobes line up with the state they describe.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module mac_operand_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic                      abort,
    output logic                      busy,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic [DATA_WIDTH-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]     mac_b,
    input  logic [3*DATA_WIDTH-1:0]   mac_cout,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [3*DATA_WIDTH-1:0]   res_data,
    output logic [LEN_WIDTH-1:0]      res_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_FEED = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [LEN_WIDTH-1:0]      rem_q, rem_d;
    logic [LEN_WIDTH-1:0]      job_len_q, job_len_d;
    logic                      wait_cnt_q, wait_cnt_d;

    logic                      busy_q, busy_d;
    logic                      op_ready_q, op_ready_d;
    logic                      mac_clr_q, mac_clr_d;
    logic                      mac_en_q, mac_en_d;
    logic [DATA_WIDTH-1:0]     mac_a_q, mac_a_d;
    logic [DATA_WIDTH-1:0]     mac_b_q, mac_b_d;
    logic                      res_valid_q, res_valid_d;
    logic [3*DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic [LEN_WIDTH-1:0]      res_count_q, res_count_d;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        job_len_d   = job_len_q;
        wait_cnt_d  = wait_cnt_q;
        mac_en_d    = 1'b0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;

        if (abort && (state_q != S_IDLE)) begin
            // Dropping the job also drops any unaccepted result.
            state_d    = S_IDLE;
            rem_d      = '0;
            wait_cnt_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_d     = len;
                        job_len_d = len;
                        state_d   = S_CLR;
                    end
                end
                S_CLR: begin
                    wait_cnt_d = 1'b0;
                    state_d    = (rem_q != '0) ? S_FEED : S_WAIT;
                end
                S_FEED: begin
                    if (op_valid && op_ready_q) begin
                        mac_en_d = 1'b1;
                        mac_a_d  = op_a;
                        mac_b_d  = op_b;
                        rem_d    = rem_q - 1'b1;
                        if (rem_q == LEN_WIDTH'(1)) begin
                            wait_cnt_d = 1'b0;
                            state_d    = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // First WAIT cycle carries mac_en for the last pair; the
                    // MAC output is final only in the second one.
                    if (wait_cnt_q) begin
                        res_data_d  = mac_cout;
                        res_count_d = job_len_q;
                        state_d     = S_DONE;
                    end else begin
                        wait_cnt_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_valid_q && res_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d      = (state_d != S_IDLE);
        op_ready_d  = (state_d == S_FEED);
        mac_clr_d   = (state_d == S_CLR);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            job_len_q   <= '0;
            wait_cnt_q  <= 1'b0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            job_len_q   <= job_len_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            op_ready_q  <= op_ready_d;
            mac_clr_q   <= mac_clr_d;
            mac_en_q    <= mac_en_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
        end
    end

    assign busy      = busy_q;
    assign op_ready  = op_ready_q;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = mac_en_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_mac_operand_seq.sv
//-----------------------------------------------------------------------------
// tb_mac_operand_seq
//
// Self-checking bench for mac_operand_seq. A behavioural MAC drives mac_cout.
// Each job's expected result is the plain sum of products modulo 2^24 and the
// expected strobe timing is derived from the job's handshake history
// (mac_clr in cycle 1, mac_en the cycle after each handshake, res_valid three
// cycles after the last handshake, or cycle 4 for an empty job).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mac_operand_seq;

    localparam int DW = 8;
    localparam int LW = 4;
    localparam int RW = 3 * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [LW-1:0]   len;
    logic            abort;
    logic            busy;
    logic            op_valid;
    logic            op_ready;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic            mac_clr;
    logic            mac_en;
    logic [DW-1:0]   mac_a;
    logic [DW-1:0]   mac_b;
    logic [RW-1:0]   mac_cout;
    logic            res_valid;
    logic            res_ready;
    logic [RW-1:0]   res_data;
    logic [LW-1:0]   res_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int overlap  = 0;

    mac_operand_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_cout  (mac_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: starts with garbage so a missing clear shows up.
    logic [RW-1:0] acc = 24'h5A5A5A;
    assign mac_cout = acc;
    always @(posedge clk) begin
        if (mac_clr)     acc <= '0;
        else if (mac_en) acc <= acc + RW'(mac_a) * RW'(mac_b);
    end

    always @(negedge clk) begin
        if (mac_en && mac_clr) overlap++;
    end

    typedef struct packed {
        logic [4:0]        n;
        logic [14:0][7:0]  a;
        logic [14:0][7:0]  b;
        logic [1:0]        vmode;
        logic [4:0]        rdelay;
        logic              poke;
        logic [23:0]       exp_res;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] ref_sum(input int n, input logic [14:0][7:0] av,
                                              input logic [14:0][7:0] bv);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(av[i]) * longint'(bv[i]);
        return RW'(s % (longint'(1) << RW));
    endfunction

    // Runs one job from IDLE; returns in IDLE the cycle after acceptance.
    task automatic run_job(input int n, input logic [14:0][7:0] av, input logic [14:0][7:0] bv,
                           input int vmode, input int rdelay, input bit poke,
                           input logic [RW-1:0] exp_res);
        int  cyc = 0;
        int  hs = 0;
        int  last_hs = 0;
        int  done_cyc;
        bit  prev_hs = 1'b0;
        start = 1'b1; len = LW'(n); op_valid = 1'b0; res_ready = 1'b0;
        forever begin
            step();
            cyc++;
            start = 1'b0;
            chk("mac_clr", mac_clr, (cyc == 1));
            chk("mac_en", mac_en, prev_hs);
            if (prev_hs) begin
                chk("mac_a", mac_a, av[hs-1]);
                chk("mac_b", mac_b, bv[hs-1]);
            end
            chk("op_ready", op_ready, (cyc >= 2) && (hs < n));
            done_cyc = (n == 0) ? 4 : ((hs == n) ? last_hs + 3 : 1000);
            chk("res_valid", res_valid, (cyc >= done_cyc));
            chk("busy", busy, 1);
            if (cyc >= done_cyc) break;
            if (cyc > 150) begin
                chk("job_timeout", cyc, done_cyc);
                return;
            end
            case (vmode)
                0:       op_valid = 1'b1;
                1:       op_valid = cyc[0];
                default: op_valid = 1'($urandom_range(0, 1));
            endcase
            if (hs < n) begin
                op_a = av[hs];
                op_b = bv[hs];
            end else begin
                op_a = 8'($urandom);
                op_b = 8'($urandom);
            end
            prev_hs = op_ready && op_valid;
            if (prev_hs) begin
                hs++;
                last_hs = cyc;
            end
        end
        op_valid = 1'b0;
        if (vmode == 0) chk("latency", cyc, n + 4);
        chk("res_data", res_data, exp_res);
        chk("res_count", res_count, n);
        for (int i = 0; i < rdelay; i++) begin
            start = poke && (i == 2);
            len = 4'd5;
            step();
            chk("hold_valid", res_valid, 1);
            chk("hold_busy", busy, 1);
            chk("hold_data", res_data, exp_res);
            chk("hold_count", res_count, n);
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("accept_valid", res_valid, 0);
        chk("accept_busy", busy, 0);
        $display("job len=%0d vmode=%0d result=%0d count=%0d expected=%0d cycles=%0d",
                 n, vmode, res_data, res_count, exp_res, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [14:0][7:0] ra;
        logic [14:0][7:0] rb;
        int rn;

        // Directed vector table.
        for (int i = 0; i < 6; i++) tbl[i] = '0;
        tbl[0].n = 3; tbl[0].a[0] = 2; tbl[0].b[0] = 3; tbl[0].a[1] = 4; tbl[0].b[1] = 5;
        tbl[0].a[2] = 255; tbl[0].b[2] = 255; tbl[0].exp_res = 65051;
        tbl[1] = tbl[0]; tbl[1].vmode = 1;
        tbl[2].n = 0; tbl[2].exp_res = 0;
        tbl[3].n = 2; tbl[3].a[0] = 3; tbl[3].b[0] = 4; tbl[3].a[1] = 5; tbl[3].b[1] = 6;
        tbl[3].rdelay = 10; tbl[3].poke = 1'b1; tbl[3].exp_res = 42;
        tbl[4].n = 2; tbl[4].a[0] = 10; tbl[4].b[0] = 10; tbl[4].a[1] = 10; tbl[4].b[1] = 10;
        tbl[4].exp_res = 200;
        tbl[5].n = 1; tbl[5].a[0] = 7; tbl[5].b[0] = 3; tbl[5].exp_res = 21;

        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; op_valid = 1'b0;
        op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_count", res_count, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_job(int'(tbl[i].n), tbl[i].a, tbl[i].b, int'(tbl[i].vmode),
                    int'(tbl[i].rdelay), tbl[i].poke, tbl[i].exp_res);
        end

        // abort in FEED after one of four pairs
        start = 1'b1; len = 4'd4;
        step(); start = 1'b0;
        step();
        chk("abort_feed_ready", op_ready, 1);
        op_valid = 1'b1; op_a = 5; op_b = 6;
        step(); op_valid = 1'b0;
        chk("abort_first_en", mac_en, 1);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_op_ready", op_ready, 0);
        chk("abort_mac_en", mac_en, 0);
        chk("abort_mac_clr", mac_clr, 0);
        chk("abort_res_valid", res_valid, 0);
        seen = 0;
        repeat (8) begin
            step();
            if (res_valid || busy) seen++;
        end
        chk("abort_quiet", seen, 0);
        $display("job aborted in FEED after 1 of 4 pairs");

        // reset during WAIT
        start = 1'b1; len = 4'd0;
        step(); start = 1'b0;
        step();
        chk("wait_busy", busy, 1);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("wrst_busy", busy, 0);
        chk("wrst_res_valid", res_valid, 0);
        chk("wrst_res_data", res_data, 0);
        seen = 0;
        repeat (6) begin
            step();
            if (res_valid || busy) seen++;
        end
        chk("wrst_quiet", seen, 0);
        $display("job dropped by reset in WAIT");

        ra = '0; rb = '0; ra[0] = 1; rb[0] = 1;
        run_job(1, ra, rb, 0, 0, 1'b0, 24'd1);

        // abort in DONE drops the pending result
        start = 1'b1; len = 4'd0;
        step(); start = 1'b0;
        repeat (3) step();
        chk("done_valid", res_valid, 1);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("done_abort_valid", res_valid, 0);
        chk("done_abort_busy", busy, 0);
        $display("result dropped by abort in DONE");
        step();

        // random jobs against the sum-of-products model
        for (int j = 0; j < 8; j++) begin
            rn = $urandom_range(0, 15);
            for (int k = 0; k < 15; k++) begin
                ra[k] = 8'($urandom);
                rb[k] = 8'($urandom);
            end
            run_job(rn, ra, rb, 2, $urandom_range(0, 3), 1'b0, ref_sum(rn, ra, rb));
        end

        chk("en_clr_overlap", overlap, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
